sqrt_result_checker: RTL

Multi-cycle checker that takes a radicand and a candidate integer root, squares the root with a shift-add datapath, and decides whether the root is the correct floor square root. It is the reverse-direction companion of the square-root pipeline: the pipeline derives a root from a radicand, and this block reconstructs root² and (root+1)² and compares them against the radicand. It uses the same 2-bit comparison code as the root pipeline's comparator stages. It sits beside the square-root datapath as an in-system self-check and a bench scoreboard helper.

---
 rtl/sqrt_result_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sqrt_result_checker.sv
// Checks a candidate floor square root: squares the root with a shift-add loop,
// then compares root^2 and (root+1)^2 against the radicand.
//
// state | meaning
// IDLE  | waiting for start_i, operands latched on accept
// MUL   | one shift-add partial product per cycle, ROOT_W cycles
// ADJ   | derive (root+1)^2 = root^2 + 2*root + 1
// CMP   | register results, pulse done_o
module sqrt_result_checker #(
  parameter int ROOT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [2*ROOT_W-1:0]   radicand_i,
  input  logic [ROOT_W-1:0]     root_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [2*ROOT_W-1:0]   square_o,
  output logic [1:0]            cmp_lo_o,
  output logic [1:0]            cmp_hi_o,
  output logic                  pass_o
);

  localparam int RW = 2 * ROOT_W;
  localparam int AW = RW + 1;
  localparam int CW = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(ROOT_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADJ  = 2'd2,
    S_CMP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [RW-1:0]     r_rad;
  logic [ROOT_W-1:0] r_root;
  logic [AW-1:0]     r_acc;
  logic [AW-1:0]     r_hi;
  logic [CW-1:0]     r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [RW-1:0]     r_square;
  logic [1:0]        r_cmp_lo;
  logic [1:0]        r_cmp_hi;
  logic              r_pass;

  logic [AW-1:0]     w_partial;
  logic [AW-1:0]     w_hi;
  logic [AW-1:0]     w_rad_ext;
  logic [1:0]        w_lo_code;
  logic [1:0]        w_hi_code;

  // 10: A < B, 01: A > B, 00: equal
  function automatic logic [1:0] cmp_code(input logic [AW-1:0] a, input logic [AW-1:0] b);
    if (a < b)      return 2'b10;
    else if (a > b) return 2'b01;
    else            return 2'b00;
  endfunction

  assign w_partial = {{(AW-ROOT_W){1'b0}}, r_root} << r_cnt;
  assign w_hi      = r_acc + {{ROOT_W{1'b0}}, r_root, 1'b0} + AW'(1);
  assign w_rad_ext = {1'b0, r_rad};
  assign w_lo_code = cmp_code(r_acc, w_rad_ext);
  assign w_hi_code = cmp_code(r_hi, w_rad_ext);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_next = S_MUL;
      S_MUL:   if (r_cnt == LAST_CNT) w_next = S_ADJ;
      S_ADJ:   w_next = S_CMP;
      S_CMP:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_rad    <= '0;
      r_root   <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_square <= '0;
      r_cmp_lo <= 2'b00;
      r_cmp_hi <= 2'b00;
      r_pass   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_rad  <= radicand_i;
            r_root <= root_i;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
        end
        S_MUL: begin
          if (r_root[r_cnt]) r_acc <= r_acc + w_partial;
          r_cnt <= r_cnt + CW'(1);
        end
        S_ADJ: r_hi <= w_hi;
        S_CMP: begin
          r_square <= r_acc[RW-1:0];
          r_cmp_lo <= w_lo_code;
          r_cmp_hi <= w_hi_code;
          r_pass   <= (w_lo_code != 2'b01) && (w_hi_code == 2'b01);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign square_o = r_square;
  assign cmp_lo_o = r_cmp_lo;
  assign cmp_hi_o = r_cmp_hi;
  assign pass_o   = r_pass;

endmodule
